// File: rtl/pipeline_controller_pkg.sv
// rtl/pipeline_controller_pkg.sv - shared encodings for the pipeline controller
package pipeline_controller_pkg;

  localparam int PIPE_CTRL_STATE_LEN = 2;

  typedef enum logic [PIPE_CTRL_STATE_LEN-1:0] {
    ST_RUN        = 2'd0,
    ST_IF_WAIT    = 2'd1,
    ST_IF_DISCARD = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } pipe_state_e;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'd0;
  localparam fwd_sel_t FWD_MEM = 2'd1;
  localparam fwd_sel_t FWD_WB  = 2'd2;

  // A writing, non-x0 destination that names the given source register
  function automatic logic rd_hits(input logic [4:0] rd, input logic we, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// rtl/pipeline_controller_hazard_detect.sv - RAW comparator and forward selects (PIPE_FORWARDING_EN)
module hazard_detect
  import pipeline_controller_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  output logic       stall,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b
);

`ifdef PIPE_FORWARDING_EN
  // Only a load in EX cannot be bypassed in time; everything else forwards
  always_comb begin
    stall = ex_is_load &&
            ((id_uses_rs1 && rd_hits(ex_rd, ex_reg_write, id_rs1)) ||
             (id_uses_rs2 && rd_hits(ex_rd, ex_reg_write, id_rs2)));
  end

  // Youngest producer wins: MEM before WB, register file otherwise
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (rd_hits(mem_rd, mem_reg_write, ex_rs1))      fwd_a = FWD_MEM;
    else if (rd_hits(wb_rd, wb_reg_write, ex_rs1))   fwd_a = FWD_WB;
    if (rd_hits(mem_rd, mem_reg_write, ex_rs2))      fwd_b = FWD_MEM;
    else if (rd_hits(wb_rd, wb_reg_write, ex_rs2))   fwd_b = FWD_WB;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_is_load, wb_rd, wb_reg_write, ex_rs1, ex_rs2};

  // No bypass network: hold ID until producers in EX and MEM have reached WB
  always_comb begin
    stall = (id_uses_rs1 && (rd_hits(ex_rd, ex_reg_write, id_rs1) ||
                             rd_hits(mem_rd, mem_reg_write, id_rs1))) ||
            (id_uses_rs2 && (rd_hits(ex_rd, ex_reg_write, id_rs2) ||
                             rd_hits(mem_rd, mem_reg_write, id_rs2)));
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
  end
`endif

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - 5-stage pipeline sequencing FSM, stall counter (PIPE_FORWARDING_EN)
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             ex_reg_write,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             pc_sel_target,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  pipe_state_e      state_q, state_d;
  pipe_state_e      resume_q, resume_d;
  pipe_state_e      eff_state;
  logic [4:0]       ex_rs1_q, ex_rs1_d;
  logic [4:0]       ex_rs2_q, ex_rs2_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             hz_stall;
  logic             mem_stall;

  hazard_detect u_hazard_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_is_load    (ex_is_load),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .ex_rs1        (ex_rs1_q),
    .ex_rs2        (ex_rs2_q),
    .stall         (hz_stall),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  assign mem_stall   = dmem_req && !dmem_ready;
  // The cycle a data wait completes behaves like the state it interrupted
  assign eff_state   = (state_q == ST_MEM_WAIT) ? resume_q : state_q;
  assign stall_count = stall_count_q;

  // Priority resolution: data wait, redirect, RAW stall, fetch wait
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    pc_sel_target = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    state_d       = state_q;
    resume_d      = resume_q;
    if (mem_stall) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      mem_wb_bubble = 1'b1;
      state_d       = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) resume_d = state_q;
    end else if (ex_redirect) begin
      pc_sel_target = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      // A fetch still in flight now belongs to the wrong PC
      state_d = (!imem_ready || eff_state == ST_IF_WAIT) ? ST_IF_DISCARD : ST_RUN;
    end else begin
      if (hz_stall) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (eff_state == ST_IF_DISCARD || !imem_ready) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
      if (eff_state == ST_IF_DISCARD) state_d = imem_ready ? ST_RUN : ST_IF_DISCARD;
      else                            state_d = imem_ready ? ST_RUN : ST_IF_WAIT;
    end
  end

  // EX source capture and saturating stall counter next-state
  always_comb begin
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    stall_count_d = stall_count_q;
    if (id_ex_en) begin
      ex_rs1_d = id_rs1;
      ex_rs2_d = id_rs2;
    end
    if (!pc_en && (stall_count_q != {CNT_W{1'b1}})) stall_count_d = stall_count_q + 1'b1;
  end

  // FSM state and resume state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      resume_q <= ST_RUN;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  // Registered EX sources and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs1_q      <= 5'd0;
      ex_rs2_q      <= 5'd0;
      stall_count_q <= '0;
    end else begin
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed self-checking bench for pipeline_controller
module tb_pipeline_controller;

  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_sel_target, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam int C_NORM   = 9'b111110000;
  localparam int C_FREEZE = 9'b000000001;
  localparam int C_REDIR  = 9'b111111110;
  localparam int C_LU     = 9'b001110010;
  localparam int C_FW     = 9'b011110100;

  logic          clk;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs1, id_uses_rs2;
  logic          ex_reg_write, mem_reg_write, wb_reg_write;
  logic          ex_is_load, ex_redirect, imem_ready, dmem_req, dmem_ready;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          pc_sel_target, if_id_flush, id_ex_flush, mem_wb_bubble;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_count;
  logic [8:0]    ctl;

  int checks;
  int failures;
  int sc_exp;

  pipeline_controller #(.CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_rd         (ex_rd),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_reg_write (mem_reg_write),
    .wb_reg_write  (wb_reg_write),
    .ex_is_load    (ex_is_load),
    .ex_redirect   (ex_redirect),
    .imem_ready    (imem_ready),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .pc_sel_target (pc_sel_target),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .mem_wb_bubble (mem_wb_bubble),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .stall_count   (stall_count)
  );

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                pc_sel_target, if_id_flush, id_ex_flush, mem_wb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sel(input int on_v, input int off_v);
`ifdef PIPE_FORWARDING_EN
    return on_v;
`else
    return off_v;
`endif
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    ex_reg_write = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    ex_is_load = 1'b0; ex_redirect = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Inputs are set just after a rising edge; sample on the falling edge, then advance
  task automatic step(input string tag, input int exp_ctl, input int exp_fa, input int exp_fb);
    @(negedge clk);
    check_eq({tag, "_ctl"}, int'(ctl), exp_ctl);
    check_eq({tag, "_fa"}, int'(fwd_a), exp_fa);
    check_eq({tag, "_fb"}, int'(fwd_b), exp_fb);
    if ((exp_ctl & 9'h100) == 0 && sc_exp != SAT) sc_exp++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    sc_exp = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    sc_exp = 0;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check_eq("reset_cnt", int'(stall_count), 0);
    idle(); step("reset_idle", C_NORM, 0, 0);

    // lw x5 in EX, add x6,x5,x2 in ID
    idle(); id_rs1 = 5'd5; id_rs2 = 5'd2; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    ex_rd = 5'd5; ex_reg_write = 1'b1; ex_is_load = 1'b1;
    step("lu_c0", C_LU, 0, 0);
    idle(); id_rs1 = 5'd5; id_rs2 = 5'd2; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    mem_rd = 5'd5; mem_reg_write = 1'b1;
    step("lu_c1", sel(C_NORM, C_LU), sel(1, 0), 0);
    idle(); id_rs1 = 5'd5; id_rs2 = 5'd2; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    wb_rd = 5'd5; wb_reg_write = 1'b1;
    step("lu_c2", C_NORM, sel(2, 0), 0);
    check_eq("lu_cnt", int'(stall_count), sel(1, 2));

    // add x5 ahead of sub x7,x5,x5
    idle(); id_rs1 = 5'd5; id_rs2 = 5'd5; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    ex_rd = 5'd5; ex_reg_write = 1'b1;
    step("raw_c3", sel(C_NORM, C_LU), 0, 0);
    idle(); id_rs1 = 5'd5; id_rs2 = 5'd5; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    ex_rd = 5'd7; ex_reg_write = 1'b1; mem_rd = 5'd5; mem_reg_write = 1'b1;
    wb_rd = 5'd5; wb_reg_write = 1'b1;
    step("raw_c4", sel(C_NORM, C_LU), sel(1, 0), sel(1, 0));
    idle(); id_rs1 = 5'd5; id_rs2 = 5'd5; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    wb_rd = 5'd5; wb_reg_write = 1'b1;
    step("raw_c5", C_NORM, sel(2, 0), sel(2, 0));
    check_eq("raw_cnt", int'(stall_count), sel(1, 4));

    // x0 dependencies never stall or forward
    idle(); id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    ex_rd = 5'd0; ex_reg_write = 1'b1; ex_is_load = 1'b1;
    step("x0_load", C_NORM, 0, 0);
    idle(); mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    step("x0_fwd", C_NORM, 0, 0);

    // Taken branch while fetch outstanding, then stale fetch consumed
    idle(); ex_redirect = 1'b1; imem_ready = 1'b0;
    step("br_c0", C_REDIR, 0, 0);
    idle(); imem_ready = 1'b0; step("br_disc_wait", C_FW, 0, 0);
    idle(); step("br_disc_drop", C_FW, 0, 0);
    idle(); step("br_target", C_NORM, 0, 0);
    // Redirect with fetch ready stays in RUN
    idle(); ex_redirect = 1'b1; step("br2_c0", C_REDIR, 0, 0);
    idle(); step("br2_c1", C_NORM, 0, 0);
    // Redirect arriving in IF_WAIT discards the pending fetch
    idle(); imem_ready = 1'b0; step("ifw_c0", C_FW, 0, 0);
    idle(); ex_redirect = 1'b1; step("ifw_redir", C_REDIR, 0, 0);
    idle(); step("ifw_drop", C_FW, 0, 0);
    idle(); step("ifw_resume", C_NORM, 0, 0);
    check_eq("br_cnt", int'(stall_count), sc_exp);

    // 3-cycle data wait over a pending load-use hazard
    for (int i = 0; i < 3; i++) begin
      idle(); dmem_req = 1'b1; dmem_ready = 1'b0;
      id_rs1 = 5'd6; id_uses_rs1 = 1'b1; ex_rd = 5'd6; ex_reg_write = 1'b1; ex_is_load = 1'b1;
      step("dm_freeze", C_FREEZE, 0, 0);
    end
    idle(); dmem_req = 1'b1;
    id_rs1 = 5'd6; id_uses_rs1 = 1'b1; ex_rd = 5'd6; ex_reg_write = 1'b1; ex_is_load = 1'b1;
    step("dm_lu", C_LU, 0, 0);
    idle(); step("dm_after", C_NORM, 0, 0);
    check_eq("dm_cnt", int'(stall_count), sel(9, 12));

    // Data wait resumes into IF_DISCARD
    idle(); ex_redirect = 1'b1; imem_ready = 1'b0; step("mr_redir", C_REDIR, 0, 0);
    idle(); dmem_req = 1'b1; dmem_ready = 1'b0; step("mr_freeze", C_FREEZE, 0, 0);
    idle(); dmem_req = 1'b1; step("mr_drop", C_FW, 0, 0);
    idle(); step("mr_run", C_NORM, 0, 0);
    check_eq("mr_cnt", int'(stall_count), sel(11, 14));

    // Reset while in MEM_WAIT with IF_DISCARD pending
    idle(); ex_redirect = 1'b1; imem_ready = 1'b0; step("rw_redir", C_REDIR, 0, 0);
    idle(); dmem_req = 1'b1; dmem_ready = 1'b0; step("rw_freeze", C_FREEZE, 0, 0);
    do_reset();
    check_eq("rw_cnt", int'(stall_count), 0);
    idle(); step("rw_idle", C_NORM, 0, 0);

    // Counter saturation and reset from saturation
    for (int i = 0; i < SAT + 1; i++) begin
      idle(); imem_ready = 1'b0; step("sat_fill", C_FW, 0, 0);
    end
    check_eq("sat_cnt", int'(stall_count), SAT);
    idle(); imem_ready = 1'b0; step("sat_hold", C_FW, 0, 0);
    check_eq("sat_hold_cnt", int'(stall_count), SAT);
    do_reset();
    check_eq("sat_rst_cnt", int'(stall_count), 0);
    idle(); step("sat_rst_idle", C_NORM, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
